edge_frame_buffer: RTL
======================

// Module: edge_frame_buffer
// PURPOSE
//  Parametrised frame store between the edge-detection output and the downstream OR/combine stage.
//  Captures one frame of DATA_W-bit pixels, then replays it in forward or reverse raster order.
//  Input and output use valid/ready handshakes. A per-frame length allows sub-frames.
//  Successor to the fixed 22500x1-bit, reverse-only buffer.
// PARAMETERS
//  DATA_W  1      bits per pixel word
//  DEPTH   22500  words of storage (150x150 frame)
//  ADDR_W  15     address/length width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high
//  start      in   1       1-cycle command strobe; ignored unless state is IDLE
//  mode       in   2       sampled with start: 00 none, 01 RECEIVE, 10 SEND_FWD, 11 SEND_REV
//  len        in   ADDR_W  sampled with start: frame length in words; 0 or >DEPTH means DEPTH
//  in_valid   in   1       write-side data valid
//  in_data    in   DATA_W  write-side pixel
//  in_ready   out  1       high only in RECV state
//  out_valid  out  1       read-side data valid
//  out_data   out  DATA_W  read-side pixel, registered
//  out_ready  in   1       downstream accepts when high
//  busy       out  1       state != IDLE
//  complete   out  1       1-cycle pulse when the last word of a command is written or accepted
// BEHAVIOUR
//  Reset (sync): state IDLE, pointers 0, in_ready=0, out_valid=0, out_data=0, busy=0,
//   complete=0. Memory contents are NOT cleared. Reset mid-frame aborts without a complete pulse.
//  FSM states are IDLE, RECV, SEND and DONE.
//  - IDLE: on start with mode 01, go to RECV, wr_ptr=0. On mode 10/11, go to SEND.
//    On mode 00, stay in IDLE.
//  - Lengths: L = effective length (clamped), latched at start; mode also latched.
//  - RECV: each cycle with in_valid&&in_ready, write mem[wr_ptr]=in_data and increment wr_ptr.
//    After beat L is written, go to DONE. Throughput is 1 word/cycle.
//  - SEND: synchronous RAM with 1-cycle read latency.
//    FWD reads addresses 0..L-1; REV reads L-1..0. All L words are sent, including address 0.
//    First out_valid is 2 cycles after start. With out_ready held high, 1 word/cycle with no bubbles.
//    When out_valid && !out_ready, out_data and out_valid hold stable. A 2-entry skid is permitted.
//    After the L-th handshake (out_valid&&out_ready), go to DONE. out_valid is 0 the following cycle.
//  - DONE: complete=1 for exactly one cycle, then IDLE. busy stays high in DONE.
//  - start while busy is ignored; mode/len changes while busy have no effect.
//  - in_valid outside RECV is ignored (no write). out_ready outside SEND is don't-care.
//  - Pointer arithmetic is ADDR_W bits, with no wrap past L-1 or below 0. The REV pointer stops at 0.
//  - SEND after no prior RECV returns whatever memory holds (X in sim is acceptable).
// CONFIGURATION
//  Macro: BUFFER_OR_MERGE_EN
//  - Defined: adds port `merge in 1`, sampled with start.
//    RECEIVE with merge=1 stores mem[a] | in_data (read-modify-write).
//    Accept rate stays 1 word/cycle via a 1-stage read pipeline; complete pulses after the final write lands.
//    merge=0 behaves as a plain write.
//  - Undefined: no merge port; RECEIVE always overwrites.
// TESTING  (DATA_W=4, DEPTH=8, ADDR_W=3 unless noted)
//  1. RECV len=0 with words 1..8, no stalls -> 8 writes, complete pulse 1 cycle after the 8th beat, then IDLE.
//  2. SEND_REV len=0, out_ready=1 -> out_data 8,7,..,1; first out_valid 2 cycles after start; complete once.
//  3. SEND_FWD len=5, out_ready toggling 1010.. -> 1,2,3,4,5 each held stable while stalled, no drops or dups.
//  4. start SEND during RECV at beat 3, and in_valid during SEND -> both ignored;
//     frame contents and ordering are unchanged.
//  5. reset asserted at SEND beat 4 -> next cycle out_valid=0, busy=0, complete=0.
//     A fresh SEND_FWD then returns 1..8 (memory retained).
//  6. [BUFFER_OR_MERGE_EN] RECV 0x1,0x2..; then RECV merge=1 with 0x8 x8; then SEND_FWD -> 0x9,0xA,0xB,..,0x8|8.

Source files
------------

// File: rtl/edge_frame_buffer.sv
// edge_frame_buffer: one-frame pixel store that captures a frame and replays it forward or reversed.
// Defining BUFFER_OR_MERGE_EN adds a merge port so a receive ORs new pixels into the stored frame.
module edge_frame_buffer #(
    parameter int DATA_W = 1,
    parameter int DEPTH  = 22500,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] len,
`ifdef BUFFER_OR_MERGE_EN
    input  logic              merge,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              complete
);
    typedef enum logic [1:0] {IDLE, RECV, SEND, DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] last_idx, eff_last, wr_ptr, rd_ptr, ack_cnt;
    logic              rev, issue_done;
    logic              wr_fire, last_wr, recv_done, rd_issue, rd_at_end, out_fire, last_ack;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    // Lengths are held as the index of the last word, so a full DEPTH frame fits in ADDR_W bits.
    assign eff_last  = (len == '0 || {1'b0, len} > DEPTH_W) ? LAST_MAX : len - ADDR_W'(1);
    assign busy      = (state != IDLE);
    assign complete  = (state == DONE);
    assign wr_fire   = in_valid && in_ready;
    assign last_wr   = wr_fire && (wr_ptr == last_idx);
    assign out_fire  = out_valid && out_ready;
    assign last_ack  = (state == SEND) && out_fire && (ack_cnt == last_idx);
    assign rd_issue  = (state == SEND) && !issue_done && (!out_valid || out_ready);
    assign rd_at_end = rev ? (rd_ptr == '0) : (rd_ptr == last_idx);

`ifdef BUFFER_OR_MERGE_EN
    logic              merge_q, flush, wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data, merge_rd;

    // Merged words land one cycle after acceptance; DONE waits for the last one.
    assign in_ready  = (state == RECV) && !flush;
    assign recv_done = merge_q ? flush : last_wr;
    assign mem_we    = merge_q ? wb_valid : wr_fire;
    assign mem_wa    = merge_q ? wb_addr : wr_ptr;
    assign mem_wd    = merge_q ? (merge_rd | wb_data) : in_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            merge_q  <= 1'b0;
            flush    <= 1'b0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            if (state == IDLE && start) begin
                merge_q <= merge;
                flush   <= 1'b0;
            end else if (last_wr && merge_q) begin
                flush <= 1'b1;
            end
            wb_valid <= wr_fire && merge_q;
            wb_addr  <= wr_ptr;
            wb_data  <= in_data;
        end
    end
`else
    assign in_ready  = (state == RECV);
    assign recv_done = last_wr;
    assign mem_we    = wr_fire;
    assign mem_wa    = wr_ptr;
    assign mem_wd    = in_data;
`endif

    // NOTE: the frame store is deliberately not reset; its contents must survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
`ifdef BUFFER_OR_MERGE_EN
        merge_rd <= mem[wr_ptr];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: state_nx gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) begin
                if (mode == 2'b01)  state_nx = RECV;
                else if (mode[1])   state_nx = SEND;
            end
            RECV: if (recv_done) state_nx = DONE;
            SEND: if (last_ack)  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read data goes straight into out_data, so a stalled word simply holds in the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_idx   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ack_cnt    <= '0;
            rev        <= 1'b0;
            issue_done <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            if (state == IDLE && start) begin
                last_idx   <= eff_last;
                rev        <= mode[0];
                wr_ptr     <= '0;
                ack_cnt    <= '0;
                issue_done <= 1'b0;
                rd_ptr     <= mode[0] ? eff_last : '0;
            end
            if (wr_fire && wr_ptr != last_idx) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_issue) begin
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
                if (rd_at_end) issue_done <= 1'b1;
                else           rd_ptr <= rev ? rd_ptr - ADDR_W'(1) : rd_ptr + ADDR_W'(1);
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (state == SEND && out_fire && ack_cnt != last_idx) ack_cnt <= ack_cnt + ADDR_W'(1);
        end
    end
endmodule
